// File: rtl/occupancy_pkg.sv
// Shared types and constants for the parking-gate occupancy tracker.
package occupancy_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_COUNT = 255;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    WAIT
  } state_t;

  // Sensor codes are written as {a,b}: a is the outer beam, b the inner beam.
  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_OUTER = 2'b10;
  localparam logic [1:0] S_BOTH  = 2'b11;
  localparam logic [1:0] S_INNER = 2'b01;

endpackage

// File: rtl/occupancy_fsm.sv
// Decodes the two-beam sensor sequence of a car passage into one-cycle
// entry/exit pulses; entry_evt/exit_evt flag the edge on which they fire.
module occupancy_fsm
  import occupancy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic entry,
  output logic exit,
  output logic entry_evt,
  output logic exit_evt
);

  state_t     state;
  logic [1:0] sensors;

  assign sensors   = {a, b};
  assign entry_evt = (state == EN3) && (sensors == S_CLEAR);
  assign exit_evt  = (state == EX3) && (sensors == S_CLEAR);

  // Any jump that skips a step of a passage parks the decoder in WAIT until the gate is clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      entry <= 1'b0;
      exit  <= 1'b0;
    end else begin
      entry <= entry_evt;
      exit  <= exit_evt;
      case (state)
        IDLE: begin
          case (sensors)
            S_OUTER: state <= EN1;
            S_INNER: state <= EX1;
            S_BOTH:  state <= WAIT;
            default: state <= IDLE;
          endcase
        end
        EN1: begin
          case (sensors)
            S_BOTH:  state <= EN2;
            S_CLEAR: state <= IDLE;
            S_INNER: state <= WAIT;
            default: state <= EN1;
          endcase
        end
        EN2: begin
          case (sensors)
            S_INNER: state <= EN3;
            S_OUTER: state <= EN1;
            S_CLEAR: state <= WAIT;
            default: state <= EN2;
          endcase
        end
        EN3: begin
          case (sensors)
            S_CLEAR: state <= IDLE;
            S_BOTH:  state <= EN2;
            S_OUTER: state <= WAIT;
            default: state <= EN3;
          endcase
        end
        EX1: begin
          case (sensors)
            S_BOTH:  state <= EX2;
            S_CLEAR: state <= IDLE;
            S_OUTER: state <= WAIT;
            default: state <= EX1;
          endcase
        end
        EX2: begin
          case (sensors)
            S_OUTER: state <= EX3;
            S_INNER: state <= EX1;
            S_CLEAR: state <= WAIT;
            default: state <= EX2;
          endcase
        end
        EX3: begin
          case (sensors)
            S_CLEAR: state <= IDLE;
            S_BOTH:  state <= EX2;
            S_INNER: state <= WAIT;
            default: state <= EX3;
          endcase
        end
        default: begin
          if (sensors == S_CLEAR) state <= IDLE;
          else                    state <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/occupancy_counter.sv
// Parking-lot occupancy tracker: sequence decoder plus a saturating
// car count that updates on the same edge as the entry/exit pulse.
module occupancy_counter
  import occupancy_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             entry,
  output logic             exit,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

  logic entry_evt;
  logic exit_evt;

  occupancy_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .entry     (entry),
    .exit      (exit),
    .entry_evt (entry_evt),
    .exit_evt  (exit_evt)
  );

  // Pulses still fire at the limits; only the count refuses to wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (entry_evt && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end else if (exit_evt && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter: directed gate sequences and
// random sensor traffic checked against a path-position model of a passage.
module tb_occupancy_counter;

  localparam int WIDTH     = 8;
  localparam int MAX_COUNT = 255;

  logic             clk;
  logic             reset;
  logic             a;
  logic             b;
  logic             entry;
  logic             exit;
  logic [WIDTH-1:0] count;

  int checks   = 0;
  int failures = 0;

  occupancy_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .entry (entry),
    .exit  (exit),
    .count (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: a passage is a walk along an ordered path of sensor codes.
  // Moving one step along the path (either way) is legal; skipping is not.
  // Leaving via 00 from the first step is a retreat, from the last a completed passage.
  logic [1:0] entry_path [3] = '{2'b10, 2'b11, 2'b01};
  logic [1:0] exit_path  [3] = '{2'b01, 2'b11, 2'b10};

  int m_dir;
  int m_pos;
  bit m_illegal;
  int m_entry;
  int m_exit;
  int m_count;

  function automatic int path_pos(input int dir, input logic [1:0] code);
    for (int k = 0; k < 3; k++) begin
      if ((dir == 1) && (entry_path[k] == code)) return k + 1;
      if ((dir == 2) && (exit_path[k] == code)) return k + 1;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dir = 0; m_pos = 0; m_illegal = 0;
      m_entry = 0; m_exit = 0; m_count = 0;
    end else begin
      logic [1:0] code;
      int k;
      code = {a, b};
      m_entry = 0;
      m_exit  = 0;
      if (m_illegal) begin
        if (code == 2'b00) m_illegal = 0;
      end else if (m_dir == 0) begin
        if (code == entry_path[0]) begin
          m_dir = 1; m_pos = 1;
        end else if (code == exit_path[0]) begin
          m_dir = 2; m_pos = 1;
        end else if (code != 2'b00) begin
          m_illegal = 1;
        end
      end else if (code == 2'b00) begin
        if (m_pos == 3 && m_dir == 1) begin
          m_entry = 1;
          if (m_count < MAX_COUNT) m_count = m_count + 1;
        end else if (m_pos == 3 && m_dir == 2) begin
          m_exit = 1;
          if (m_count > 0) m_count = m_count - 1;
        end else if (m_pos == 2) begin
          m_illegal = 1;
        end
        m_dir = 0; m_pos = 0;
      end else begin
        k = path_pos(m_dir, code);
        if (k == m_pos + 1 || k == m_pos - 1) begin
          m_pos = k;
        end else if (k != m_pos) begin
          m_illegal = 1; m_dir = 0; m_pos = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one sensor code for a number of cycles, checking every cycle against the model.
  task automatic applyStimulus(input logic [1:0] code, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      {a, b} = code;
      @(negedge clk);
      checkOutput("entry", int'(entry), m_entry);
      checkOutput("exit", int'(exit), m_exit);
      checkOutput("count", int'(count), m_count);
      checkOutput("excl", int'(entry & exit), 0);
    end
  endtask

  task automatic entrySeq(input int hold);
    applyStimulus(2'b10, hold);
    applyStimulus(2'b11, hold);
    applyStimulus(2'b01, hold);
    applyStimulus(2'b00, hold);
  endtask

  task automatic exitSeq(input int hold);
    applyStimulus(2'b01, hold);
    applyStimulus(2'b11, hold);
    applyStimulus(2'b10, hold);
    applyStimulus(2'b00, hold);
  endtask

  task automatic pulseReset();
    #5 reset = 1'b1;
    #1;
    checkOutput("rst_async_count", int'(count), 0);
    checkOutput("rst_async_entry", int'(entry), 0);
    checkOutput("rst_async_exit", int'(exit), 0);
    #14 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    {a, b} = 2'b00;
    #1;
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_entry", int'(entry), 0);
    checkOutput("reset_exit", int'(exit), 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(2'b00, 2);
    entrySeq(2);
    checkOutput("entry1_count", int'(count), 1);
    entrySeq(2);
    checkOutput("entry2_count", int'(count), 2);

    pulseReset();
    checkOutput("after_rst_count", int'(count), 0);

    exitSeq(2);
    checkOutput("exit_floor_count", int'(count), 0);
    entrySeq(2);
    entrySeq(2);
    checkOutput("two_entries_count", int'(count), 2);

    // Back-up mid-entry, then a retreat from the first step.
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 2);
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 2);
    applyStimulus(2'b01, 2);
    applyStimulus(2'b00, 2);
    checkOutput("backup_count", int'(count), 3);
    applyStimulus(2'b10, 2);
    applyStimulus(2'b00, 2);
    checkOutput("retreat_count", int'(count), 3);

    // Illegal jump parks the decoder until the gate clears.
    applyStimulus(2'b10, 2);
    applyStimulus(2'b01, 2);
    applyStimulus(2'b11, 2);
    applyStimulus(2'b00, 2);
    checkOutput("illegal_count", int'(count), 3);

    // Reset while partway through an entry discards it.
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 2);
    {a, b} = 2'b00;
    pulseReset();
    applyStimulus(2'b01, 2);
    applyStimulus(2'b00, 2);
    checkOutput("rst_en2_count", int'(count), 0);

    // Fill to the ceiling, push one more, then step back down.
    for (int n = 0; n < MAX_COUNT; n++) entrySeq(1);
    checkOutput("full_count", int'(count), MAX_COUNT);
    entrySeq(1);
    checkOutput("sat_count", int'(count), MAX_COUNT);
    exitSeq(1);
    checkOutput("sat_exit_count", int'(count), MAX_COUNT - 1);

    // Random traffic: a mix of clean passages and arbitrary sensor noise.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: entrySeq(int'($urandom_range(1, 2)));
        1: exitSeq(int'($urandom_range(1, 2)));
        default: applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      endcase
    end
    applyStimulus(2'b00, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
